// File: rtl/breakout_pkg.sv
// Shared breakout constants, screen coordinate type and small encoder helpers.
// Pure declarations: no latency, no backpressure.
package breakout_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int PADDLE_W   = 80;
    localparam int DEMO_X_POS = 900;

    typedef logic [9:0] coord_t;

    typedef enum logic {
        MODE_LIVE = 1'b0,
        MODE_DEMO = 1'b1
    } mode_e;

    // Gray code {A,B} to rotary phase 0..3 along the forward direction 00->01->11->10.
    function automatic logic [1:0] gray_phase(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    function automatic logic signed [7:0] sat_add8(input logic signed [7:0] a,
                                                   input logic signed [1:0] b);
        logic signed [8:0] s;
        s = {a[7], a} + {{7{b[1]}}, b};
        if (s > 9'sd127) begin
            return 8'sd127;
        end else if (s < -9'sd128) begin
            return -8'sd128;
        end
        return s[7:0];
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// One encoder: 2-flop sync, per-contact stable filter, Gray-step decode to a signed step.
// Step appears 2 + FILT_LEN cycles after a clean pin edge; no backpressure.
module quad_decoder
    import breakout_pkg::*;
#(
    parameter int FILT_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              quad_a_i,
    input  logic              quad_b_i,
    output logic signed [1:0] step_o
);

    localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

    logic [1:0] sync1_q, sync2_q;
    logic [1:0] filt_q, filt_d;
    logic [1:0] prev_q;
    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];
    logic [1:0] phase_diff;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            cnt_d[i]  = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            prev_q  <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            sync1_q <= {quad_a_i, quad_b_i};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            cnt_q   <= cnt_d;
        end
    end

    // A phase difference of 2 means both contacts moved at once: ignored.
    assign phase_diff = gray_phase(filt_q) - gray_phase(prev_q);

    always_comb begin
        step_o = 2'sb00;
        if (phase_diff == 2'd1) begin
            step_o = 2'sb01;
        end else if (phase_diff == 2'd3) begin
            step_o = 2'sb11;
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle X controller: encoder steps accumulate per frame, applied and clamped on vSync rise.
// Outputs registered, valid the cycle after the apply edge; no backpressure.
module paddle_ctrl
    import breakout_pkg::*;
#(
    parameter int PADDLE_MIN  = 0,
    parameter int PADDLE_MAX  = SCREEN_W - PADDLE_W,
    parameter int STEP_PX     = 4,
    parameter int FILT_LEN    = 16,
    parameter int IDLE_FRAMES = 600,
    parameter int DEMO_X      = DEMO_X_POS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       quadA,
    input  logic       quadB,
    input  logic       vSync,
    output logic [9:0] PaddleX,
    output logic       demo,
    output logic       moved
);

    localparam coord_t             RESET_POS = coord_t'((PADDLE_MIN + PADDLE_MAX) / 2);
    localparam coord_t             DEMO_C    = coord_t'(DEMO_X);
    localparam logic signed [11:0] MIN_S     = 12'(PADDLE_MIN);
    localparam logic signed [11:0] MAX_S     = 12'(PADDLE_MAX);
    localparam logic signed [11:0] STEP_S    = 12'(STEP_PX);
    localparam logic [11:0]        IDLE_MAX  = 12'(IDLE_FRAMES);

    logic signed [1:0]  step;
    logic               vsync_q;
    logic               apply;
    logic signed [7:0]  acc_q, acc_d;
    logic               acc_nz;
    coord_t             live_pos_q, live_pos_d;
    logic [11:0]        idle_q, idle_d;
    logic signed [11:0] scaled, sum, clamped;
    mode_e              state_q, state_d;
    coord_t             paddle_x_q, paddle_x_d;
    logic               demo_q, demo_d;
    logic               moved_q, moved_d;

    quad_decoder #(
        .FILT_LEN (FILT_LEN)
    ) u_quad_decoder (
        .clk      (clk),
        .rst_n    (rst_n),
        .quad_a_i (quadA),
        .quad_b_i (quadB),
        .step_o   (step)
    );

    assign apply  = vSync & ~vsync_q;
    assign acc_nz = (acc_q != 8'sd0);

    // A step landing on the apply cycle seeds the next frame rather than being dropped.
    assign acc_d = apply ? {{6{step[1]}}, step} : sat_add8(acc_q, step);

    always_comb begin
        scaled  = {{4{acc_q[7]}}, acc_q} * STEP_S;
        sum     = $signed({2'b00, live_pos_q}) + scaled;
        clamped = sum;
        if (sum < MIN_S) begin
            clamped = MIN_S;
        end else if (sum > MAX_S) begin
            clamped = MAX_S;
        end
        live_pos_d = apply ? clamped[9:0] : live_pos_q;
    end

    always_comb begin
        idle_d = idle_q;
        if (apply) begin
            if (acc_nz) begin
                idle_d = '0;
            end else if (idle_q != IDLE_MAX) begin
                idle_d = idle_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q    <= 1'b1;
            acc_q      <= '0;
            live_pos_q <= RESET_POS;
            idle_q     <= '0;
        end else begin
            vsync_q    <= vSync;
            acc_q      <= acc_d;
            live_pos_q <= live_pos_d;
            idle_q     <= idle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MODE_DEMO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (apply) begin
            if (acc_nz) begin
                state_d = MODE_LIVE;
            end else if (idle_d == IDLE_MAX) begin
                state_d = MODE_DEMO;
            end
        end
    end

    always_comb begin
        paddle_x_d = (state_d == MODE_DEMO) ? DEMO_C : live_pos_d;
        demo_d     = (state_d == MODE_DEMO);
        moved_d    = apply & acc_nz;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            paddle_x_q <= DEMO_C;
            demo_q     <= 1'b1;
            moved_q    <= 1'b0;
        end else begin
            paddle_x_q <= paddle_x_d;
            demo_q     <= demo_d;
            moved_q    <= moved_d;
        end
    end

    assign PaddleX = paddle_x_q;
    assign demo    = demo_q;
    assign moved   = moved_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed plus randomized checks of paddle_ctrl against a frame-level behavioural model.
module tb_paddle_ctrl;

    localparam int FILT_LEN    = 16;
    localparam int IDLE_FRAMES = 3;
    localparam int STEP_PX     = 4;
    localparam int P_MIN       = 0;
    localparam int P_MAX       = 560;
    localparam int DEMO_XV     = 900;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       quadA = 1'b0;
    logic       quadB = 1'b0;
    logic       vSync = 1'b1;
    logic [9:0] PaddleX;
    logic       demo;
    logic       moved;

    paddle_ctrl #(
        .PADDLE_MIN  (P_MIN),
        .PADDLE_MAX  (P_MAX),
        .STEP_PX     (STEP_PX),
        .FILT_LEN    (FILT_LEN),
        .IDLE_FRAMES (IDLE_FRAMES),
        .DEMO_X      (DEMO_XV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .quadA   (quadA),
        .quadB   (quadB),
        .vSync   (vSync),
        .PaddleX (PaddleX),
        .demo    (demo),
        .moved   (moved)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int moved_cnt = 0;

    always @(negedge clk) if (moved === 1'b1) moved_cnt++;

    // Reference model: encoder phase and per-frame paddle state.
    logic [1:0] gray_tab [4];
    int phase  = 0;
    int m_acc  = 0;
    int m_pos  = (P_MIN + P_MAX) / 2;
    int m_idle = 0;
    bit m_demo = 1'b1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc  = 0;
        m_pos  = (P_MIN + P_MAX) / 2;
        m_idle = 0;
        m_demo = 1'b1;
        phase  = 0;
    endtask

    task automatic model_apply(output int exp_mv);
        if (m_acc != 0) begin
            m_pos = m_pos + m_acc * STEP_PX;
            if (m_pos < P_MIN) m_pos = P_MIN;
            if (m_pos > P_MAX) m_pos = P_MAX;
            m_idle = 0;
            m_demo = 1'b0;
            exp_mv = 1;
        end else begin
            if (m_idle < IDLE_FRAMES) m_idle++;
            if (m_idle == IDLE_FRAMES) m_demo = 1'b1;
            exp_mv = 0;
        end
        m_acc = 0;
    endtask

    function automatic int exp_x();
        return m_demo ? DEMO_XV : m_pos;
    endfunction

    // d = +1 forward, -1 reverse, 2 = both contacts flip together (illegal, no step).
    task automatic drive_edge(input int d);
        @(posedge clk);
        #1;
        phase = (phase + d + 4) % 4;
        {quadA, quadB} = gray_tab[phase];
        if (d == 1 && m_acc < 127) m_acc++;
        if (d == -1 && m_acc > -128) m_acc--;
        repeat (FILT_LEN + 3 + $urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic edges(input int n, input int d);
        for (int i = 0; i < n; i++) drive_edge(d);
    endtask

    task automatic frame(input string tag);
        int mc0;
        int exp_mv;
        @(posedge clk);
        #1 vSync = 1'b1;
        mc0 = moved_cnt;
        @(posedge clk);
        #1;
        model_apply(exp_mv);
        check({tag, "_x"}, int'(PaddleX), exp_x());
        check({tag, "_demo"}, int'(demo), int'(m_demo));
        check({tag, "_moved"}, int'(moved), exp_mv);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 vSync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_pulses"}, moved_cnt - mc0, exp_mv);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int mc0;
        int exp_mv;
        int r;
        gray_tab = '{2'b00, 2'b01, 2'b11, 2'b10};

        // Reset with vSync held high across release.
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_x", int'(PaddleX), DEMO_XV);
        check("reset_demo", int'(demo), 1);
        check("reset_moved", moved_cnt, 0);
        vSync = 1'b0;
        repeat (2) @(posedge clk);

        edges(3, 1);
        frame("fwd3");
        check("fwd3_abs", int'(PaddleX), 292);

        // Contact A bounce one sample short of the filter length.
        @(posedge clk);
        #1 quadA = ~quadA;
        repeat (FILT_LEN - 1) @(posedge clk);
        #1 quadA = ~quadA;
        repeat (FILT_LEN + 4) @(posedge clk);
        frame("bounce");

        edges(65, 1);
        frame("to552");
        check("to552_abs", int'(PaddleX), 552);
        edges(5, 1);
        frame("clamp5");
        check("clamp5_abs", int'(PaddleX), 560);
        edges(10, 1);
        frame("clamp10");

        edges(70, -1);
        frame("back280");
        check("back280_abs", int'(PaddleX), 280);
        edges(200, -1);
        frame("sat");
        check("sat_abs", int'(PaddleX), 0);

        frame("idle1");
        frame("idle2");
        frame("idle3");
        check("idle3_demo_abs", int'(demo), 1);
        edges(1, 1);
        frame("resume");
        check("resume_abs", int'(PaddleX), 4);

        // Both contacts flipping together is ignored.
        drive_edge(2);
        frame("illegal");

        // Step landing on the same edge as the apply belongs to the next frame.
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
        {quadA, quadB} = gray_tab[phase];
        repeat (FILT_LEN + 2) @(posedge clk);
        #1 vSync = 1'b1;
        mc0 = moved_cnt;
        @(posedge clk);
        #1;
        model_apply(exp_mv);
        check("coinc_moved", int'(moved), exp_mv);
        check("coinc_x", int'(PaddleX), exp_x());
        m_acc = 1;
        @(posedge clk);
        #1 vSync = 1'b0;
        repeat (FILT_LEN + 4) @(posedge clk);
        frame("coinc_next");

        // Randomized frames.
        for (int f = 0; f < 10; f++) begin
            for (int e = 0; e < int'($urandom_range(0, 8)); e++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0) drive_edge(2);
                else if (r < 6) drive_edge(1);
                else drive_edge(-1);
            end
            frame($sformatf("rnd%0d", f));
        end

        // Reset with motion pending and a pin edge still in the filter.
        edges(2, 1);
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
        {quadA, quadB} = gray_tab[phase];
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        {quadA, quadB} = 2'b00;
        vSync = 1'b0;
        mc0 = moved_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (FILT_LEN + 4) @(posedge clk);
        #1;
        check("rst2_x", int'(PaddleX), DEMO_XV);
        check("rst2_demo", int'(demo), 1);
        check("rst2_moved", moved_cnt - mc0, 0);
        frame("rst2_empty");
        edges(1, 1);
        frame("rst2_fwd");
        check("rst2_fwd_abs", int'(PaddleX), 284);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
